// File: rtl/pong_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pong_pkg                                                             |
// | Shared stage indices and sequencer state encoding for the Pong       |
// | datapath. Revision: 1.0                                              |
// +----------------------------------------------------------------------+
package pong_pkg;

  localparam int NUM_STG = 4;

  localparam logic [1:0] STG_PADDLE  = 2'd0;
  localparam logic [1:0] STG_BALL    = 2'd1;
  localparam logic [1:0] STG_COLLIDE = 2'd2;
  localparam logic [1:0] STG_SCORE   = 2'd3;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_WAIT  = 2'd2
  } seq_state_t;

  function automatic logic [NUM_STG-1:0] stage_onehot(input logic [1:0] s);
    stage_onehot    = '0;
    stage_onehot[s] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wdog_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wdog_timer                                                           |
// | Loadable down-counter that flags the cycle in which it reaches zero. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wdog_timer #(
  parameter int CYCLES = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic expire
);

  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(CYCLES);
  localparam logic [W-1:0] ONE      = W'(1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && count != '0) begin
      count <= count - ONE;
    end
  end

  // Flags the decrement that takes the count to zero.
  assign expire = dec && (count == ONE);

endmodule
`default_nettype wire

// File: rtl/frame_update_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_update_sequencer                                               |
// | Once per frame, starts paddle, ball, collide and (on a hit/miss)     |
// | score units in order, waiting for each unit's done pulse.            |
// | Option: define PONG_SEQ_WDOG_EN to add a per-stage watchdog.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module frame_update_sequencer
  import pong_pkg::*;
#(
  parameter int WDOG_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       run,
  input  logic       score_req,
  input  logic [3:0] stg_done,
  output logic [3:0] stg_start,
  output logic [1:0] cur_stage,
  output logic       busy,
  output logic       overrun,
  input  logic       overrun_clr,
  output logic       wdog_err
);

  seq_state_t state;
  logic [1:0] stage;
  logic       done_hit;
  logic       wdog_expire;

  assign done_hit = stg_done[stage];

`ifdef PONG_SEQ_WDOG_EN
  wdog_timer #(
    .CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .load   (state == SEQ_ISSUE),
    .dec    (state == SEQ_WAIT),
    .expire (wdog_expire)
  );
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^WDOG_CYCLES;
  assign wdog_expire     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEQ_IDLE;
      stage     <= STG_PADDLE;
      stg_start <= '0;
      cur_stage <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      wdog_err  <= 1'b0;
    end else begin
      stg_start <= '0;

      // A tick landing on a running sequence is dropped; set beats clear.
      if (frame_tick && state != SEQ_IDLE) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end

      case (state)
        SEQ_IDLE: begin
          if (frame_tick && run) begin
            stage     <= STG_PADDLE;
            cur_stage <= STG_PADDLE;
            stg_start <= stage_onehot(STG_PADDLE);
            busy      <= 1'b1;
            state     <= SEQ_ISSUE;
          end
        end
        SEQ_ISSUE: begin
          state <= SEQ_WAIT;
        end
        SEQ_WAIT: begin
          if (done_hit) begin
            if (stage == STG_SCORE || (stage == STG_COLLIDE && !score_req)) begin
              busy  <= 1'b0;
              state <= SEQ_IDLE;
            end else begin
              stage     <= stage + 2'd1;
              cur_stage <= stage + 2'd1;
              stg_start <= stage_onehot(stage + 2'd1);
              state     <= SEQ_ISSUE;
            end
          end else if (wdog_expire) begin
            wdog_err <= 1'b1;
            busy     <= 1'b0;
            state    <= SEQ_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= SEQ_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_update_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_frame_update_sequencer                                            |
// | Scoreboard bench: expected start pulses are queued per frame and     |
// | matched against the DUT. Revision: 1.0                               |
// +----------------------------------------------------------------------+
module tb_frame_update_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       run = 1'b0;
  logic       score_req = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [3:0] stg_done;
  logic [3:0] auto_done = 4'b0;
  logic [3:0] man_done = 4'b0;
  logic [3:0] resp_en = 4'hF;
  logic [3:0] stg_start;
  logic [1:0] cur_stage;
  logic       busy;
  logic       overrun;
  logic       wdog_err;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int done_due[4] = '{-1, -1, -1, -1};

  typedef struct {
    int stage;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  assign stg_done = auto_done | man_done;

  frame_update_sequencer #(
    .WDOG_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .run         (run),
    .score_req   (score_req),
    .stg_done    (stg_done),
    .stg_start   (stg_start),
    .cur_stage   (cur_stage),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .wdog_err    (wdog_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Model of the units: each enabled unit answers 3 cycles after its start.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 4; k++) auto_done[k] = (done_due[k] == cyc);
  end

  always @(negedge clk) begin
    if (!reset && stg_start != 4'b0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL start_unexpected: got stg_start=%b at cycle %0d, required no start", stg_start, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (stg_start !== (4'b0001 << e.stage) || cur_stage !== 2'(e.stage) || cyc !== e.cyc) begin
          n_bad++;
          $display("FAIL start_seq: got stg_start=%b cur_stage=%0d cycle=%0d, required stage %0d at cycle %0d",
                   stg_start, cur_stage, cyc, e.stage, e.cyc);
        end
      end
      for (int k = 0; k < 4; k++)
        if (stg_start[k] && resp_en[k]) done_due[k] = cyc + 3;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int stage, input int at);
    exp_t e;
    e.stage = stage;
    e.cyc   = at;
    exp_q.push_back(e);
  endtask

  task automatic tick_now(output int t);
    step();
    t = cyc;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic wait_idle(output int fall);
    fall = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        fall = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    @(negedge clk);
    n_cmp++; if (stg_start !== 4'b0) begin n_bad++; $display("FAIL reset_stg_start: got %b, required 0000", stg_start); end
    n_cmp++; if (cur_stage !== 2'b0) begin n_bad++; $display("FAIL reset_cur_stage: got %0d, required 0", cur_stage); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
    n_cmp++; if (wdog_err !== 1'b0) begin n_bad++; $display("FAIL reset_wdog_err: got %b, required 0", wdog_err); end
    step();
    reset = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_score_path();
    int t, f;
    run = 1'b1; score_req = 1'b1;
    tick_now(t);
    push_exp(0, t + 1); push_exp(1, t + 5); push_exp(2, t + 9); push_exp(3, t + 13);
    wait_idle(f);
    n_cmp++; if (f !== t + 17) begin n_bad++; $display("FAIL score_busy_fall: got cycle %0d, required %0d", f, t + 17); end
    repeat (4) step();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL score_missing: got %0d starts pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_skip_score();
    int t, f;
    run = 1'b1; score_req = 1'b0;
    tick_now(t);
    push_exp(0, t + 1); push_exp(1, t + 5); push_exp(2, t + 9);
    wait_idle(f);
    n_cmp++; if (f !== t + 13) begin n_bad++; $display("FAIL skip_busy_fall: got cycle %0d, required %0d", f, t + 13); end
    repeat (6) step();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL skip_missing: got %0d starts pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_overrun();
    int t, f;
    run = 1'b1; score_req = 1'b1;
    tick_now(t);
    push_exp(0, t + 1); push_exp(1, t + 5); push_exp(2, t + 9); push_exp(3, t + 13);
    step(); frame_tick = 1'b1;
    @(negedge clk);
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_early: got %b, required 0", overrun); end
    step(); frame_tick = 1'b0;
    @(negedge clk);
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_set: got %b, required 1", overrun); end
    step(); frame_tick = 1'b1; overrun_clr = 1'b1;
    step(); frame_tick = 1'b0; overrun_clr = 1'b0;
    @(negedge clk);
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_set_wins: got %b, required 1", overrun); end
    step(); overrun_clr = 1'b1;
    step(); overrun_clr = 1'b0;
    @(negedge clk);
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_clear: got %b, required 0", overrun); end
    wait_idle(f);
    n_cmp++; if (f !== t + 17) begin n_bad++; $display("FAIL overrun_busy_fall: got cycle %0d, required %0d", f, t + 17); end
    repeat (6) step();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL overrun_missing: got %0d starts pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_wrong_done();
    int t, f;
    run = 1'b1; score_req = 1'b0; resp_en = 4'b1110;
    tick_now(t);
    push_exp(0, t + 1); push_exp(1, t + 5); push_exp(2, t + 9);
    man_done = 4'b0001;
    step();
    man_done = 4'b0100;
    step();
    man_done = 4'b0000;
    @(negedge clk);
    n_cmp++; if (cur_stage !== 2'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL wrong_done_hold: got cur_stage=%0d busy=%b, required 0 and 1", cur_stage, busy); end
    step(); man_done = 4'b0001;
    step(); man_done = 4'b0000;
    wait_idle(f);
    n_cmp++; if (f !== t + 13) begin n_bad++; $display("FAIL wrong_done_fall: got cycle %0d, required %0d", f, t + 13); end
    resp_en = 4'hF;
    repeat (4) step();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL wrong_done_missing: got %0d starts pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_run_low();
    int t, f;
    int seen = 0;
    run = 1'b1; score_req = 1'b0;
    tick_now(t);
    push_exp(0, t + 1); push_exp(1, t + 5); push_exp(2, t + 9);
    step(); run = 1'b0;
    wait_idle(f);
    n_cmp++; if (f !== t + 13) begin n_bad++; $display("FAIL run_low_fall: got cycle %0d, required %0d", f, t + 13); end
    step(); frame_tick = 1'b1;
    step(); frame_tick = 1'b0;
    repeat (8) begin @(negedge clk); if (busy) seen = 1; end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL run_low_start: got busy=1 after tick with run low, required 0"); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL run_low_missing: got %0d starts pending, required 0", exp_q.size()); exp_q.delete(); end
    run = 1'b1;
  endtask

  task automatic test_reset_mid();
    int t, f;
    run = 1'b1; score_req = 1'b1;
    tick_now(t);
    push_exp(0, t + 1); push_exp(1, t + 5);
    repeat (5) step();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || stg_start !== 4'b0 || cur_stage !== 2'd0) begin n_bad++; $display("FAIL reset_mid_outputs: got busy=%b stg_start=%b cur_stage=%0d, required 0", busy, stg_start, cur_stage); end
    step(); reset = 1'b0;
    repeat (3) step();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_mid_idle: got busy=%b, required 0", busy); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL reset_mid_pending: got %0d starts pending, required 0", exp_q.size()); exp_q.delete(); end
    tick_now(t);
    push_exp(0, t + 1); push_exp(1, t + 5); push_exp(2, t + 9); push_exp(3, t + 13);
    wait_idle(f);
    n_cmp++; if (f !== t + 17) begin n_bad++; $display("FAIL reset_mid_restart: got cycle %0d, required %0d", f, t + 17); end
    repeat (4) step();
  endtask

`ifdef PONG_SEQ_WDOG_EN
  task automatic test_watchdog();
    int t;
    run = 1'b1; score_req = 1'b1; resp_en = 4'b1101;
    tick_now(t);
    push_exp(0, t + 1); push_exp(1, t + 5);
    repeat (12) step();
    @(negedge clk);
    n_cmp++; if (wdog_err !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL wdog_early: got wdog_err=%b busy=%b, required 0 and 1", wdog_err, busy); end
    step();
    @(negedge clk);
    n_cmp++; if (wdog_err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL wdog_fire: got wdog_err=%b busy=%b, required 1 and 0", wdog_err, busy); end
    repeat (6) step();
    n_cmp++; if (exp_q.size() != 0 || wdog_err !== 1'b1) begin n_bad++; $display("FAIL wdog_after: got pending=%0d wdog_err=%b, required 0 and 1", exp_q.size(), wdog_err); exp_q.delete(); end
    resp_en = 4'hF;
  endtask
`else
  task automatic test_stall();
    int t, d, f;
    run = 1'b1; score_req = 1'b1; resp_en = 4'b1101;
    tick_now(t);
    push_exp(0, t + 1); push_exp(1, t + 5);
    repeat (30) step();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || wdog_err !== 1'b0 || cur_stage !== 2'd1) begin n_bad++; $display("FAIL stall_hold: got busy=%b wdog_err=%b cur_stage=%0d, required 1, 0, 1", busy, wdog_err, cur_stage); end
    step(); d = cyc; man_done = 4'b0010;
    push_exp(2, d + 1); push_exp(3, d + 5);
    step(); man_done = 4'b0000;
    resp_en = 4'hF;
    wait_idle(f);
    n_cmp++; if (f !== d + 9) begin n_bad++; $display("FAIL stall_fall: got cycle %0d, required %0d", f, d + 9); end
    repeat (4) step();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL stall_missing: got %0d starts pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: got no finish by 200000, required finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset();
    test_score_path();
    test_skip_score();
    test_overrun();
    test_wrong_done();
    test_run_low();
    test_reset_mid();
`ifdef PONG_SEQ_WDOG_EN
    test_watchdog();
`else
    test_stall();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_update_sequencer.md
# frame_update_sequencer

Per-frame scheduler for the Pong game datapath. Once per video frame it issues start pulses to the paddle, ball, collision and score units in a fixed order. It advances only when each unit reports done, so no unit ever sees half-updated positions. It sits between the VGA sync generator (frame tick) and the game datapath, gated by the game-state controller's run indication.

## Interface
Parameters:
- WDOG_CYCLES, 1023: max cycles a stage may take before the watchdog aborts; counter width is $clog2(WDOG_CYCLES+1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clk
- frame_tick  in  1  one-cycle pulse at start of vertical blank (pixel x==0, y==0)
- run  in  1  high while game is in play; low inhibits new sequences
- score_req  in  1  collision unit's hit/miss flag, sampled at collide-stage done
- stg_done  in  4  per-stage done pulses: [0] paddle, [1] ball, [2] collide, [3] score
- stg_start  out  4  one-hot, one-cycle start pulses, same bit order
- cur_stage  out  2  index of stage currently issued/awaited
- busy  out  1  high from ISSUE of stage 0 until return to IDLE
- overrun  out  1  sticky: frame_tick arrived while busy
- overrun_clr  in  1  clears overrun
- wdog_err  out  1  sticky watchdog error, cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: frame_tick && run loads stage=0 and moves to ISSUE. A frame_tick with run low is ignored silently.
- ISSUE: stg_start[stage]=1 for exactly one cycle, then WAIT.
- WAIT: only stg_done[stage] is honoured; other done bits are ignored.
  - On done with stage<2: stage+1, go to ISSUE.
  - On done with stage==2: latch score_req. If 1, stage=3 and go to ISSUE; if 0, go to IDLE (score stage skipped).
  - On done with stage==3: go to IDLE.
- stg_done asserted during the ISSUE cycle is ignored. Units must respond no earlier than the cycle after start.
- run falling mid-sequence does not abort: the sequence completes, and no new one starts.
- frame_tick while busy: tick is dropped and overrun is set. If overrun_clr and a set condition occur in the same cycle, set wins.
- Reset (any time, including mid-sequence): state=IDLE, stage=0. All outputs go to 0: stg_start, cur_stage, busy, overrun, wdog_err.

## Timing
- frame_tick sampled high in cycle N → stg_start[0] high in cycle N+1 (registered output); busy high from N+1.
- stg_done[k] sampled high in WAIT cycle M:
  - next stage's stg_start in cycle M+1, or
  - busy low in M+1 if the sequence ends.
- Minimum sequence length: 2 cycles per stage, giving 8 cycles with score and 6 without.
- cur_stage updates in the same cycle as the corresponding stg_start.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- PONG_SEQ_WDOG_EN defined:
  - Watchdog loaded with WDOG_CYCLES on ISSUE and decremented each WAIT cycle.
  - Reaching 0 without done sets wdog_err and returns to IDLE, abandoning the sequence.
  - A done sampled in the same cycle the count reaches 0 wins; no error.
- PONG_SEQ_WDOG_EN undefined: no counter; WAIT holds indefinitely; wdog_err tied 0.

## Structure
- Shared package pong_pkg:
  - stage constants STG_PADDLE=0, STG_BALL=1, STG_COLLIDE=2, STG_SCORE=3
  - sequencer state encoding
  - stage count NUM_STG=4
- Sub-module wdog_timer (load/decrement/expire), instantiated only under PONG_SEQ_WDOG_EN.

## Test plan
- Reset mid-WAIT at stage 1 → next cycle all outputs 0, state IDLE; next frame_tick starts cleanly at stage 0.
- run=1, frame_tick in cycle 10, each done 3 cycles after its start, score_req=1 → stg_start pulses in cycles 11, 15, 19, 23; busy falls in cycle 27.
- Same stimulus with score_req=0 → stg_start[3] never pulses; busy falls in cycle 23.
- frame_tick in cycle 12 during sequence → overrun=1 from cycle 13; overrun_clr plus new overrun in the same cycle → overrun stays 1.
- Wrong-stage done (stg_done[2] pulsed while waiting on stage 0) → ignored, stage stays 0; done during the ISSUE cycle → ignored.
- PONG_SEQ_WDOG_EN, WDOG_CYCLES=8, ball unit never done → wdog_err=1 after 8 WAIT cycles, busy=0, collide/score never started.
